// File: rtl/fullconnect_pkg.sv
// Shared definitions for the full-connect read/write buffers: word width,
// FSM state encoding and line-geometry helpers.
package fullconnect_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fc_state_e;

  function automatic int fc_wpl(input int data_width);
    return data_width / WORD_WIDTH;
  endfunction

  // A single-word line still needs a 1-bit index to keep port widths legal.
  function automatic int fc_idx_width(input int wpl);
    return (wpl > 1) ? $clog2(wpl) : 1;
  endfunction

endpackage

// File: rtl/FullConnectDFF.sv
// Plain register primitive with asynchronous active-low clear, shared by the
// full-connect control paths.
module FullConnectDFF #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Control state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= {WIDTH{1'b0}};
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/fullconnect_word_unpack.sv
// Combinational selector picking one 32-bit word out of a wide read line;
// word 0 sits in the least-significant bits.
module fullconnect_word_unpack
  import fullconnect_pkg::*;
#(
  parameter int AvalonData_WIDTH = 512,
  parameter int IDX_W            = 4
) (
  input  logic [AvalonData_WIDTH-1:0] i_line,
  input  logic [IDX_W-1:0]            i_idx,
  output logic [WORD_WIDTH-1:0]       o_word
);

  localparam int WPL = fc_wpl(AvalonData_WIDTH);

  logic [WORD_WIDTH-1:0] w_words [WPL];

  for (genvar g = 0; g < WPL; g++) begin : g_split
    assign w_words[g] = i_line[g*WORD_WIDTH +: WORD_WIDTH];
  end

  // Word select; indices past the end of a non-power-of-two line read as zero.
  always_comb begin
    if (int'(i_idx) < WPL) begin
      o_word = w_words[i_idx];
    end else begin
      o_word = {WORD_WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/fullconnect_read_buffer.sv
// Two-slot ping-pong buffer between the Avalon ReadMaster and the MAC:
// fetches wide lines on command and streams them out as 32-bit words.
module fullconnect_read_buffer
  import fullconnect_pkg::*;
#(
  parameter int AvalonData_WIDTH = 512,
  parameter int NumWords_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        Start_i,
  input  logic [NumWords_WIDTH-1:0]   NumWords_i,
  output logic                        Done_o,
  output logic                        ReadReq_o,
  input  logic                        ReadAck_i,
  input  logic [AvalonData_WIDTH-1:0] ReadData_i,
  output logic                        Valid_o,
  input  logic                        Halt_i,
  output logic [WORD_WIDTH-1:0]       Data_o,
  output logic                        Last_o
);

  localparam int WPL   = fc_wpl(AvalonData_WIDTH);
  localparam int IDX_W = fc_idx_width(WPL);
  localparam int NW    = NumWords_WIDTH;

  logic [1:0]            r_state_q;
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_occ;
  logic [NW-1:0]         r_remaining;
  logic [NW-1:0]         r_fetch_left;
  logic [IDX_W-1:0]      r_word_idx;
  logic                  r_done;
  logic [AvalonData_WIDTH-1:0] r_slot [2];

  fc_state_e             w_state;
  fc_state_e             w_state_nxt;
  logic                  w_run;
  logic                  w_req;
  logic                  w_take;
  logic                  w_valid;
  logic                  w_xfer;
  logic                  w_rem_one;
  logic                  w_free;
  logic [1:0]            w_occ_nxt;
  logic                  w_rd_nxt;
  logic                  w_wr_nxt;
  logic [NW-1:0]         w_fetch_ceil;
  logic [WORD_WIDTH-1:0] w_word;

  assign w_state   = fc_state_e'(r_state_q);
  assign w_run     = (w_state == ST_RUN);
  // Request credit comes from registered occupancy only, so a slot freed this
  // cycle is re-requested on the next one.
  assign w_req     = w_run & (r_fetch_left != {NW{1'b0}}) & (r_occ < 2'd2);
  assign w_take    = w_req & ReadAck_i;
  assign w_valid   = w_run & (r_occ != 2'd0);
  assign w_xfer    = w_valid & ~Halt_i;
  assign w_rem_one = (r_remaining == NW'(1));
  assign w_free    = w_xfer & ((r_word_idx == IDX_W'(WPL - 1)) | w_rem_one);
  assign w_occ_nxt = r_occ + {1'b0, w_take} - {1'b0, w_free};
  assign w_rd_nxt  = r_rd_ptr ^ w_free;
  assign w_wr_nxt  = r_wr_ptr ^ w_take;

  assign w_fetch_ceil = (NumWords_i / NW'(WPL))
                      + (((NumWords_i % NW'(WPL)) != {NW{1'b0}}) ? NW'(1) : NW'(0));

  FullConnectDFF #(.WIDTH(2)) u_state_dff (.clk(clk), .rstn(rstn), .d(w_state_nxt), .q(r_state_q));
  FullConnectDFF #(.WIDTH(1)) u_rd_dff    (.clk(clk), .rstn(rstn), .d(w_rd_nxt),    .q(r_rd_ptr));
  FullConnectDFF #(.WIDTH(1)) u_wr_dff    (.clk(clk), .rstn(rstn), .d(w_wr_nxt),    .q(r_wr_ptr));
  FullConnectDFF #(.WIDTH(2)) u_occ_dff   (.clk(clk), .rstn(rstn), .d(w_occ_nxt),   .q(r_occ));

  // Next-state logic; a zero-length command completes without leaving IDLE.
  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      ST_IDLE: begin
        if (Start_i && (NumWords_i != {NW{1'b0}})) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_xfer && w_rem_one) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Word/line counters and the completion pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_remaining  <= {NW{1'b0}};
      r_fetch_left <= {NW{1'b0}};
      r_word_idx   <= {IDX_W{1'b0}};
      r_done       <= 1'b0;
    end else begin
      r_done <= ((w_state == ST_IDLE) & Start_i & (NumWords_i == {NW{1'b0}}))
              | (w_xfer & w_rem_one);
      if ((w_state == ST_IDLE) && Start_i) begin
        r_remaining  <= NumWords_i;
        r_fetch_left <= w_fetch_ceil;
      end else begin
        if (w_xfer) r_remaining <= r_remaining - NW'(1);
        if (w_take) r_fetch_left <= r_fetch_left - NW'(1);
      end
      if (w_free) begin
        r_word_idx <= {IDX_W{1'b0}};
      end else if (w_xfer) begin
        r_word_idx <= r_word_idx + IDX_W'(1);
      end
    end
  end

  // Line storage needs no reset: a slot is only read after it was written.
  always_ff @(posedge clk) begin
    if (w_take) r_slot[r_wr_ptr] <= ReadData_i;
  end

  fullconnect_word_unpack #(
    .AvalonData_WIDTH(AvalonData_WIDTH),
    .IDX_W           (IDX_W)
  ) u_unpack (
    .i_line(r_slot[r_rd_ptr]),
    .i_idx (r_word_idx),
    .o_word(w_word)
  );

  assign Done_o    = r_done;
  assign ReadReq_o = w_req;
  assign Valid_o   = w_valid;
  assign Last_o    = w_valid & w_rem_one;
  assign Data_o    = w_valid ? w_word : {WORD_WIDTH{1'b0}};

endmodule

// File: tb/tb_fullconnect_read_buffer.sv
// Directed bench for fullconnect_read_buffer: a ReadMaster stand-in acks two
// cycles after each request; line L word i carries {L[15:0], i[15:0]}.
module tb_fullconnect_read_buffer;

  localparam int AW  = 512;
  localparam int NW  = 16;
  localparam int WPL = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          Start_i = 1'b0;
  logic [NW-1:0] NumWords_i = '0;
  logic          Done_o;
  logic          ReadReq_o;
  logic          ReadAck_i = 1'b0;
  logic [AW-1:0] ReadData_i = '0;
  logic          Valid_o;
  logic          Halt_i = 1'b0;
  logic [31:0]   Data_o;
  logic          Last_o;

  fullconnect_read_buffer #(.AvalonData_WIDTH(AW), .NumWords_WIDTH(NW)) dut (
    .clk(clk), .rstn(rstn), .Start_i(Start_i), .NumWords_i(NumWords_i),
    .Done_o(Done_o), .ReadReq_o(ReadReq_o), .ReadAck_i(ReadAck_i),
    .ReadData_i(ReadData_i), .Valid_o(Valid_o), .Halt_i(Halt_i),
    .Data_o(Data_o), .Last_o(Last_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] got_data[$];
  bit          got_last[$];
  int          got_cycle[$];
  int done_cnt, done_cycle, req_cnt, stab_err, req_err, valid_err, lines_acked;
  bit timed_out;

  function automatic logic [AW-1:0] mk_line(input int l);
    logic [AW-1:0] v;
    for (int i = 0; i < WPL; i++) v[i*32 +: 32] = {16'(l), 16'(i)};
    return v;
  endfunction

  function automatic logic [31:0] exp_word(input int k);
    return {16'(k / WPL), 16'(k % WPL)};
  endfunction

  // Drives one command and records everything; the model tracks expected
  // ReadReq_o/Valid_o cycle by cycle.
  task automatic run_cmd(input int nw, input bit alt_halt, input int abort_after, input int pulse_at);
    int cyc, wait_cnt, k, fl, occ, rem;
    bit run, prev_hold, done_seen;
    logic [31:0] prev_data;
    logic prev_last;
    got_data.delete(); got_last.delete(); got_cycle.delete();
    done_cnt = 0; done_cycle = -1; req_cnt = 0; stab_err = 0; req_err = 0;
    valid_err = 0; lines_acked = 0; timed_out = 1'b0;
    cyc = 0; wait_cnt = 0; k = 0; occ = 0; prev_hold = 1'b0; done_seen = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    @(negedge clk);
    Start_i = 1'b1; NumWords_i = NW'(nw); Halt_i = 1'b0;
    run = (nw > 0); rem = nw; fl = (nw + WPL - 1) / WPL;
    while (cyc < 3000 && !done_seen) begin
      @(negedge clk);
      cyc++;
      Start_i = 1'b0;
      ReadAck_i = 1'b0;
      if (cyc == pulse_at) begin Start_i = 1'b1; NumWords_i = NW'(3); end
      if (ReadReq_o !== (run && fl > 0 && occ < 2)) req_err++;
      if (Valid_o !== (run && occ > 0)) valid_err++;
      if (Done_o === 1'b1) begin done_cnt++; done_cycle = cyc; done_seen = 1'b1; end
      if (prev_hold && (Data_o !== prev_data || Last_o !== prev_last)) stab_err++;
      if (abort_after >= 0 && k == abort_after) begin
        rstn = 1'b0;
        break;
      end
      if (ReadReq_o === 1'b1) begin
        wait_cnt++;
        if (wait_cnt == 2) begin
          ReadAck_i = 1'b1; ReadData_i = mk_line(lines_acked);
          lines_acked++; req_cnt++; wait_cnt = 0; fl--; occ++;
        end
      end
      Halt_i = alt_halt ? ~Halt_i : 1'b0;
      prev_hold = (Valid_o === 1'b1) && Halt_i; prev_data = Data_o; prev_last = Last_o;
      if (Valid_o === 1'b1 && !Halt_i) begin
        got_data.push_back(Data_o); got_last.push_back(Last_o); got_cycle.push_back(cyc);
        if ((k % WPL) == WPL - 1 || k == nw - 1) occ--;
        rem--; k++;
        if (rem == 0) run = 1'b0;
      end
    end
    if (!done_seen && abort_after < 0) timed_out = 1'b1;
    ReadAck_i = 1'b0; Halt_i = 1'b0; Start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (Done_o === 1'b1) done_cnt++;
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (Done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", Done_o); end
    n_checks++; if (ReadReq_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", ReadReq_o); end
    n_checks++; if (Valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", Valid_o); end
    n_checks++; if (Last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", Last_o); end
    n_checks++; if (Data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", Data_o); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_line();
    run_cmd(16, 1'b0, -1, -1);
    n_checks++; if (got_data.size() != 16) begin n_fail++; $display("FAIL single_count: got %0d expected 16", got_data.size()); end
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++; if (got_data[k] !== 32'(k)) begin n_fail++; $display("FAIL single_word%0d: got %h expected %h", k, got_data[k], 32'(k)); end
      n_checks++; if (got_last[k] !== (k == 15)) begin n_fail++; $display("FAIL single_last%0d: got %b expected %b", k, got_last[k], (k == 15)); end
    end
    if (got_data.size() == 16) begin
      n_checks++; if (got_cycle[15] - got_cycle[0] != 15) begin n_fail++; $display("FAIL single_consecutive: got span %0d expected 15", got_cycle[15] - got_cycle[0]); end
      n_checks++; if (done_cycle != got_cycle[15] + 1) begin n_fail++; $display("FAIL single_done_time: got %0d expected %0d", done_cycle, got_cycle[15] + 1); end
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL single_done_cnt: got %0d expected 1", done_cnt); end
    n_checks++; if (req_cnt != 1) begin n_fail++; $display("FAIL single_req_cnt: got %0d expected 1", req_cnt); end
    n_checks++; if (req_err != 0 || valid_err != 0) begin n_fail++; $display("FAIL single_handshake: got req_err %0d valid_err %0d expected 0 0", req_err, valid_err); end
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL single_timeout: got timeout expected done"); end
  endtask

  task automatic test_partial_line();
    run_cmd(20, 1'b0, -1, -1);
    n_checks++; if (got_data.size() != 20) begin n_fail++; $display("FAIL partial_count: got %0d expected 20", got_data.size()); end
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++; if (got_data[k] !== exp_word(k)) begin n_fail++; $display("FAIL partial_word%0d: got %h expected %h", k, got_data[k], exp_word(k)); end
      n_checks++; if (got_last[k] !== (k == 19)) begin n_fail++; $display("FAIL partial_last%0d: got %b expected %b", k, got_last[k], (k == 19)); end
    end
    n_checks++; if (req_cnt != 2) begin n_fail++; $display("FAIL partial_req_cnt: got %0d expected 2", req_cnt); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL partial_done_cnt: got %0d expected 1", done_cnt); end
    n_checks++; if (req_err != 0 || valid_err != 0) begin n_fail++; $display("FAIL partial_handshake: got req_err %0d valid_err %0d expected 0 0", req_err, valid_err); end
  endtask

  task automatic test_back_pressure();
    run_cmd(48, 1'b1, -1, -1);
    n_checks++; if (got_data.size() != 48) begin n_fail++; $display("FAIL bp_count: got %0d expected 48", got_data.size()); end
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++; if (got_data[k] !== exp_word(k)) begin n_fail++; $display("FAIL bp_word%0d: got %h expected %h", k, got_data[k], exp_word(k)); end
    end
    n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL bp_hold_stable: got %0d changes expected 0", stab_err); end
    n_checks++; if (req_err != 0) begin n_fail++; $display("FAIL bp_req_timing: got %0d errors expected 0", req_err); end
    n_checks++; if (valid_err != 0) begin n_fail++; $display("FAIL bp_valid: got %0d errors expected 0", valid_err); end
    n_checks++; if (req_cnt != 3) begin n_fail++; $display("FAIL bp_req_cnt: got %0d expected 3", req_cnt); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_zero_and_ignored();
    run_cmd(0, 1'b0, -1, -1);
    n_checks++; if (done_cycle != 1) begin n_fail++; $display("FAIL zero_done_time: got %0d expected 1", done_cycle); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done_cnt: got %0d expected 1", done_cnt); end
    n_checks++; if (req_cnt != 0 || req_err != 0) begin n_fail++; $display("FAIL zero_no_req: got req_cnt %0d req_err %0d expected 0 0", req_cnt, req_err); end
    n_checks++; if (got_data.size() != 0) begin n_fail++; $display("FAIL zero_no_words: got %0d expected 0", got_data.size()); end
    run_cmd(16, 1'b0, -1, 5);
    n_checks++; if (got_data.size() != 16) begin n_fail++; $display("FAIL ignored_count: got %0d expected 16", got_data.size()); end
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++; if (got_data[k] !== 32'(k)) begin n_fail++; $display("FAIL ignored_word%0d: got %h expected %h", k, got_data[k], 32'(k)); end
    end
    n_checks++; if (done_cnt != 1 || req_cnt != 1) begin n_fail++; $display("FAIL ignored_counts: got done %0d req %0d expected 1 1", done_cnt, req_cnt); end
    n_checks++; if (req_err != 0 || valid_err != 0) begin n_fail++; $display("FAIL ignored_handshake: got req_err %0d valid_err %0d expected 0 0", req_err, valid_err); end
  endtask

  task automatic test_spurious_and_reset();
    @(negedge clk);
    ReadAck_i = 1'b1; ReadData_i = {AW{1'b1}};
    repeat (2) begin
      @(negedge clk);
      n_checks++; if (Valid_o !== 1'b0 || ReadReq_o !== 1'b0) begin n_fail++; $display("FAIL spurious_idle: got valid %b req %b expected 0 0", Valid_o, ReadReq_o); end
    end
    ReadAck_i = 1'b0;
    run_cmd(16, 1'b0, -1, -1);
    n_checks++; if (got_data.size() != 16) begin n_fail++; $display("FAIL spurious_count: got %0d expected 16", got_data.size()); end
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++; if (got_data[k] !== 32'(k)) begin n_fail++; $display("FAIL spurious_word%0d: got %h expected %h", k, got_data[k], 32'(k)); end
    end
    run_cmd(32, 1'b0, 5, -1);
    #1;
    n_checks++; if ({Done_o, ReadReq_o, Valid_o, Last_o} !== 4'b0000 || Data_o !== 32'h0) begin n_fail++; $display("FAIL abort_outputs: got done %b req %b valid %b last %b data %h expected all 0", Done_o, ReadReq_o, Valid_o, Last_o, Data_o); end
    n_checks++; if (got_data.size() != 5) begin n_fail++; $display("FAIL abort_words: got %0d expected 5", got_data.size()); end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
    rstn = 1'b1;
    @(negedge clk);
    n_checks++; if (Done_o !== 1'b0 || Valid_o !== 1'b0) begin n_fail++; $display("FAIL abort_release: got done %b valid %b expected 0 0", Done_o, Valid_o); end
    run_cmd(16, 1'b0, -1, -1);
    n_checks++; if (got_data.size() != 16) begin n_fail++; $display("FAIL rerun_count: got %0d expected 16", got_data.size()); end
    for (int k = 0; k < got_data.size(); k++) begin
      n_checks++; if (got_data[k] !== 32'(k)) begin n_fail++; $display("FAIL rerun_word%0d: got %h expected %h", k, got_data[k], 32'(k)); end
    end
    n_checks++; if (done_cnt != 1 || req_cnt != 1) begin n_fail++; $display("FAIL rerun_counts: got done %0d req %0d expected 1 1", done_cnt, req_cnt); end
    n_checks++; if (req_err != 0 || valid_err != 0) begin n_fail++; $display("FAIL rerun_handshake: got req_err %0d valid_err %0d expected 0 0", req_err, valid_err); end
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_partial_line();
    test_back_pressure();
    test_zero_and_ignored();
    test_spurious_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
